// File: rtl/shift_reg_univ.sv
// Universal W-bit register: hold, load, shift, rotate, clear and set, with a saturating
// shift-out counter and an Empty flag that rises as soon as the loaded word is drained.
module shift_reg_univ #(
    parameter int W  = 8,
    parameter int CW = 6
) (
    input  logic          Ck,
    input  logic          ClrN,
    input  logic          En,
    input  logic [2:0]    M,
    input  logic [W-1:0]  D,
    input  logic          SIL,
    input  logic          SIR,
    output logic [W-1:0]  Q,
    output logic [W-1:0]  QN,
    output logic          SOL,
    output logic          SOR,
    output logic [CW-1:0] Cnt,
    output logic          Empty
);

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_LOAD  = 3'b001,
        MODE_SHL   = 3'b010,
        MODE_SHR   = 3'b011,
        MODE_ROL   = 3'b100,
        MODE_ROR   = 3'b101,
        MODE_CLEAR = 3'b110,
        MODE_SET   = 3'b111
    } mode_t;

    localparam logic [CW-1:0] CNT_FULL = CW'(W);

    logic [W-1:0]  q_reg;
    logic [W-1:0]  q_next;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic [CW-1:0] cnt_inc;
    logic          empty_reg;

    logic [W-1:0]  shl_val;
    logic [W-1:0]  shr_val;
    logic [W-1:0]  rol_val;
    logic [W-1:0]  ror_val;

    // Per-bit neighbour selection; the end bits take either the serial input or the wrapped bit.
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bit
            if (gi == 0) begin : g_lsb
                assign shl_val[gi] = SIL;
                assign rol_val[gi] = q_reg[W-1];
            end else begin : g_lmid
                assign shl_val[gi] = q_reg[gi-1];
                assign rol_val[gi] = q_reg[gi-1];
            end
            if (gi == W-1) begin : g_msb
                assign shr_val[gi] = SIR;
                assign ror_val[gi] = q_reg[0];
            end else begin : g_rmid
                assign shr_val[gi] = q_reg[gi+1];
                assign ror_val[gi] = q_reg[gi+1];
            end
        end
    endgenerate

    assign cnt_inc = (cnt_reg == CNT_FULL) ? CNT_FULL : cnt_reg + CW'(1);

    // An unknown mode falls through to default, so the register simply holds.
    always_comb begin
        q_next   = q_reg;
        cnt_next = cnt_reg;
        if (En) begin
            case (mode_t'(M))
                MODE_HOLD: ;
                MODE_LOAD: begin
                    q_next   = D;
                    cnt_next = '0;
                end
                MODE_SHL: begin
                    q_next   = shl_val;
                    cnt_next = cnt_inc;
                end
                MODE_SHR: begin
                    q_next   = shr_val;
                    cnt_next = cnt_inc;
                end
                MODE_ROL:  q_next = rol_val;
                MODE_ROR:  q_next = ror_val;
                MODE_CLEAR: begin
                    q_next   = '0;
                    cnt_next = '0;
                end
                MODE_SET: begin
                    q_next   = '1;
                    cnt_next = '0;
                end
                default: ;
            endcase
        end
    end

    // Empty is computed from the next count so it asserts on the same edge Cnt reaches W.
    always_ff @(posedge Ck or negedge ClrN) begin
        if (!ClrN) begin
            q_reg     <= '0;
            cnt_reg   <= '0;
            empty_reg <= 1'b0;
        end else begin
            q_reg     <= q_next;
            cnt_reg   <= cnt_next;
            empty_reg <= (cnt_next == CNT_FULL);
        end
    end

    assign Q     = q_reg;
    assign QN    = ~q_reg;
    assign SOL   = q_reg[W-1];
    assign SOR   = q_reg[0];
    assign Cnt   = cnt_reg;
    assign Empty = empty_reg;

endmodule

// File: doc/shift_reg_univ.md
Name: shift_reg_univ

Overview:
Parametrised universal register, the edge-triggered, multi-bit successor to the single-bit D latch with Q/QN outputs. It holds W bits and supports hold, parallel load, shift left/right with serial input, rotate left/right, clear and set. It tracks how many bits have been shifted out since the last load and flags when the loaded word is exhausted. It serves as a building block for serial/parallel conversion and datapath registers.

Parameters:
W, 8, register width in bits (legal range 2..32)
CW, 6, width of shift counter Cnt; must satisfy 2^CW > W

Ports:
Ck  input  1  clock; all state updates on rising edge
ClrN  input  1  asynchronous active-low reset
En  input  1  operation enable; 0 forces hold regardless of M
M  input  3  mode select (encoding below)
D  input  W  parallel load data
SIL  input  1  serial input entering at bit 0 on shift left
SIR  input  1  serial input entering at bit W-1 on shift right
Q  output  W  register contents
QN  output  W  bitwise complement of Q, always ~Q, never X when Q is known
SOL  output  1  bit shifted out on shift left = Q[W-1] (combinational from Q)
SOR  output  1  bit shifted out on shift right = Q[0] (combinational from Q)
Cnt  output  CW  shifts performed since last load/clear/set, saturating at W
Empty  output  1  1 when Cnt == W (every loaded bit has left via a shift)

Behaviour:
- Reset: ClrN=0 asynchronously forces Q=0, QN=all ones, Cnt=0, Empty=0. Held while low. Release takes effect at the first rising Ck edge after deassertion.
- All other updates occur on rising Ck edge, 1-cycle latency: new Q is visible after the edge.
- En=0: Q and Cnt hold; M is ignored.
- En=1, M encoding:
  - 000 hold: Q and Cnt unchanged.
  - 001 load: Q<=D; Cnt<=0.
  - 010 shift left: Q<={Q[W-2:0],SIL}; Cnt<=min(Cnt+1,W).
  - 011 shift right: Q<={SIR,Q[W-1:1]}; Cnt<=min(Cnt+1,W).
  - 100 rotate left: Q<={Q[W-2:0],Q[W-1]}; Cnt unchanged.
  - 101 rotate right: Q<={Q[0],Q[W-1:1]}; Cnt unchanged.
  - 110 clear: Q<=0; Cnt<=0.
  - 111 set: Q<=all ones; Cnt<=0.
- Cnt saturates at W; further shifts keep Cnt=W and Empty=1, and Q keeps shifting normally.
- Empty is registered, derived from next-state Cnt, so it rises in the same cycle Cnt reaches W.
- Mixing directions (left then right) still increments Cnt per shift; no direction tracking.
- X/Z on M while En=1 is illegal. The bench flags it, and the design holds state.
- ClrN asserted mid-operation overrides any mode immediately, without waiting for Ck.
- QN, SOL and SOR are purely combinational from Q; there are no additional registers.

Test Plan:
- Reset: ClrN=0 with Ck running, M=001, D=8'hA5 -> Q=8'h00, QN=8'hFF, Cnt=0, Empty=0 throughout. Release ClrN, 1 edge with load -> Q=8'hA5, QN=8'h5A.
- Shift left drain: load 8'hA5, then 8 edges M=010 with SIL=0 -> SOL sequence before each edge 1,0,1,0,0,1,0,1. Final Q=8'h00, Cnt=8, Empty=1. A 9th shift keeps Cnt=8, Empty=1.
- Shift right with serial in: load 8'h00, 4 edges M=011 with SIR=1 -> Q=8'hF0, Cnt=4, Empty=0.
- Rotate: load 8'h81, M=100 one edge -> Q=8'h03; M=101 two edges -> Q=8'hC0; Cnt stays 0.
- Enable/hold: load 8'h3C, En=0 with M=010 for 3 edges -> Q=8'h3C, Cnt=0. M=110 -> Q=0. M=111 -> Q=8'hFF, QN=8'h00.
- Mid-op reset: after 5 shifts (Cnt=5), pulse ClrN low between edges -> Q=0, Cnt=0 immediately. Repeat at W=16 and W=2 for parameter coverage.
